// File: rtl/simon_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : simon_frame_seq
// Purpose  : Turns a one-symbol command into a timed 128-bit MAX7219 frame
//            (symbol for ON_CYCLES, blank for OFF_CYCLES, then a done pulse).
//            Optional blink during SHOW when SIMON_FRAME_BLINK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module simon_frame_seq #(
  parameter int ON_CYCLES    = 50_000_000,
  parameter int OFF_CYCLES   = 25_000_000,
  parameter int BLINK_CYCLES = 5_000_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  input  logic [2:0]   cmd_symbol,
  output logic         cmd_ready,
  input  logic         cmd_abort,
  output logic [127:0] led_on,
  output logic         busy,
  output logic         done
);

  localparam int MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int CW      = ($clog2(MAX_CYC + 1) > 0) ? $clog2(MAX_CYC + 1) : 1;
  localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
  localparam logic [CW-1:0] OFF_LOAD = CW'((OFF_CYCLES > 0) ? OFF_CYCLES - 1 : 0);
  localparam logic [127:0]  BLANK    = 128'h0100_0200_0300_0400_0500_0600_0700_0800;

  if ((ON_CYCLES < 1) || (OFF_CYCLES < 0) || (BLINK_CYCLES < 1)) begin : g_param_check
    $error("simon_frame_seq: illegal cycle parameters");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [127:0]    led_q, led_d;
  logic            done_q, done_d;

`ifdef SIMON_FRAME_BLINK_EN
  localparam int BW = ($clog2(BLINK_CYCLES) > 0) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 1);
  logic [2:0]      sym_q, sym_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            phase_q, phase_d;
`endif

  // Word k carries digit address k+1 so the frame is never an all-zero no-op.
  function automatic logic [127:0] frame_of(input logic [2:0] s);
    logic [63:0]  r;
    logic [127:0] f;
    case (s)
      3'd1:    r = 64'h183C_7EFF_1818_1818;
      3'd2:    r = 64'h080C_0EFF_FF0E_0C08;
      3'd3:    r = 64'h1818_1818_FF7E_3C18;
      3'd4:    r = 64'h1030_70FF_FF70_3010;
      3'd5:    r = 64'h0001_0306_8CD8_7020;
      3'd6:    r = 64'h8142_2418_1824_4281;
      3'd7:    r = 64'hFFFF_FFFF_FFFF_FFFF;
      default: r = 64'h0;
    endcase
    f = '0;
    for (int k = 0; k < 8; k++) begin
      f[127-16*k -: 16] = {8'(k + 1), r[63-8*k -: 8]};
    end
    return f;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    done_d  = 1'b0;
`ifdef SIMON_FRAME_BLINK_EN
    sym_d   = sym_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
`endif
    if (cmd_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      led_d   = BLANK;
`ifdef SIMON_FRAME_BLINK_EN
      bcnt_d  = '0;
      phase_d = 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_d = S_SHOW;
            cnt_d   = ON_LOAD;
            led_d   = frame_of(cmd_symbol);
`ifdef SIMON_FRAME_BLINK_EN
            sym_d   = cmd_symbol;
            bcnt_d  = BLINK_LOAD;
            phase_d = 1'b1;
`endif
          end
        end
        S_SHOW: begin
          if (cnt_q == '0) begin
            led_d = BLANK;
            if (OFF_CYCLES > 0) begin
              state_d = S_GAP;
              cnt_d   = OFF_LOAD;
            end else begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
`ifdef SIMON_FRAME_BLINK_EN
            // phase_q high means the glyph is on screen
            if (bcnt_q == '0) begin
              phase_d = ~phase_q;
              bcnt_d  = BLINK_LOAD;
              led_d   = phase_q ? BLANK : frame_of(sym_q);
            end else begin
              bcnt_d  = bcnt_q - BW'(1);
            end
`endif
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          led_d   = BLANK;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      led_q   <= BLANK;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

`ifdef SIMON_FRAME_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sym_q   <= '0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      sym_q   <= sym_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end
`endif

  assign led_on    = led_q;
  assign done      = done_q;
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_simon_frame_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_frame_seq
// Purpose  : Directed self-checking bench for simon_frame_seq (ON=4, OFF=2,
//            BLINK=2, plus a second instance with OFF=0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_frame_seq;

  localparam logic [127:0] BLANK = 128'h0100_0200_0300_0400_0500_0600_0700_0800;
  localparam logic [127:0] FULL  = 128'h01FF_02FF_03FF_04FF_05FF_06FF_07FF_08FF;
  localparam logic [127:0] UP    = 128'h0118_023C_037E_04FF_0518_0618_0718_0818;
  localparam logic [127:0] RIGHT = 128'h0108_020C_030E_04FF_05FF_060E_070C_0808;
  localparam logic [127:0] LEFT  = 128'h0110_0230_0370_04FF_05FF_0670_0730_0810;
  localparam logic [127:0] CHK   = 128'h0100_0201_0303_0406_058C_06D8_0770_0820;
  localparam logic [127:0] CROSS = 128'h0181_0242_0324_0418_0518_0624_0742_0881;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0, abort = 1'b0;
  logic [2:0]   sym = 3'd0;
  logic         ready, busy, done;
  logic [127:0] led;
  logic         valid0 = 1'b0, abort0 = 1'b0;
  logic [2:0]   sym0 = 3'd0;
  logic         ready0, busy0, done0;
  logic [127:0] led0;

  int n_chk = 0;
  int n_err = 0;
  int dcnt;

  always #5 clk = ~clk;

  simon_frame_seq #(.ON_CYCLES(4), .OFF_CYCLES(2), .BLINK_CYCLES(2)) u_dut (
    .clk(clk), .rst(rst), .cmd_valid(valid), .cmd_symbol(sym), .cmd_ready(ready),
    .cmd_abort(abort), .led_on(led), .busy(busy), .done(done)
  );

  simon_frame_seq #(.ON_CYCLES(4), .OFF_CYCLES(0), .BLINK_CYCLES(2)) u_dut0 (
    .clk(clk), .rst(rst), .cmd_valid(valid0), .cmd_symbol(sym0), .cmd_ready(ready0),
    .cmd_abort(abort0), .led_on(led0), .busy(busy0), .done(done0)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected SHOW frame for SHOW cycle i (0..3)
  function automatic logic [127:0] sx(input logic [127:0] f, input int i);
`ifdef SIMON_FRAME_BLINK_EN
    return (((i / 2) % 2) == 0) ? f : BLANK;
`else
    return f;
`endif
  endfunction

  initial begin
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_led", led, BLANK);
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));

    // symbol 7: 4 cycles full, 2 blank, done
    valid = 1'b1; sym = 3'd7;
    step();
    valid = 1'b0;
    chk("s7_show0", led, sx(FULL, 0));
    chk("s7_busy", 128'(busy), 128'(1));
    chk("s7_ready", 128'(ready), 128'(0));
    for (int i = 1; i < 4; i++) begin
      step();
      chk("s7_show", led, sx(FULL, i));
    end
    step();
    chk("s7_gap0", led, BLANK);
    chk("s7_gap0_done", 128'(done), 128'(0));
    chk("s7_gap0_busy", 128'(busy), 128'(1));
    step();
    chk("s7_gap1", led, BLANK);
    chk("s7_gap1_done", 128'(done), 128'(0));
    step();
    chk("s7_done", 128'(done), 128'(1));
    chk("s7_done_ready", 128'(ready), 128'(1));
    chk("s7_done_busy", 128'(busy), 128'(0));
    chk("s7_done_led", led, BLANK);
    step();
    chk("s7_done_pulse", 128'(done), 128'(0));

    // right, with cmd_valid held (symbol 6) through the whole command
    valid = 1'b1; sym = 3'd2;
    step();
    sym = 3'd6;
    chk("hold_show0", led, sx(RIGHT, 0));
    for (int i = 1; i < 4; i++) begin
      step();
      chk("hold_show", led, sx(RIGHT, i));
    end
    step();
    step();
    chk("hold_gap_busy", 128'(busy), 128'(1));
    chk("hold_gap_done", 128'(done), 128'(0));
    step();
    chk("hold_done", 128'(done), 128'(1));
    chk("hold_done_ready", 128'(ready), 128'(1));
    step();
    valid = 1'b0;
    chk("b2b_show0", led, sx(CROSS, 0));
    chk("b2b_busy", 128'(busy), 128'(1));
    chk("b2b_done", 128'(done), 128'(0));

    // abort on second SHOW cycle
    step();
    chk("ab_show1", led, sx(CROSS, 1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_led", led, BLANK);
    chk("ab_busy", 128'(busy), 128'(0));
    chk("ab_ready", 128'(ready), 128'(1));
    chk("ab_done", 128'(done), 128'(0));
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      dcnt += int'(done);
    end
    chk("ab_no_done", 128'(dcnt), 128'(0));

    // abort beats a command in IDLE
    abort = 1'b1; valid = 1'b1; sym = 3'd7;
    step();
    abort = 1'b0; valid = 1'b0;
    chk("abidle_busy", 128'(busy), 128'(0));
    chk("abidle_led", led, BLANK);
    step();
    chk("abidle_busy2", 128'(busy), 128'(0));

    // symbol 0: blank frame, full timing
    valid = 1'b1; sym = 3'd0;
    step();
    valid = 1'b0;
    chk("s0_busy", 128'(busy), 128'(1));
    chk("s0_led", led, BLANK);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      dcnt += int'(done);
    end
    chk("s0_no_early_done", 128'(dcnt), 128'(0));
    step();
    chk("s0_done", 128'(done), 128'(1));

    // reset mid-SHOW
    valid = 1'b1; sym = 3'd4;
    step();
    valid = 1'b0;
    chk("rs_show0", led, sx(LEFT, 0));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rs_led", led, BLANK);
    chk("rs_busy", 128'(busy), 128'(0));
    chk("rs_done", 128'(done), 128'(0));
    dcnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      dcnt += int'(done);
    end
    chk("rs_no_done", 128'(dcnt), 128'(0));

    // OFF_CYCLES=0 instance, symbol up
    valid0 = 1'b1; sym0 = 3'd1;
    step();
    valid0 = 1'b0;
    chk("z_word0", 128'(led0[127:112]), 128'(16'h0118));
    chk("z_show0", led0, sx(UP, 0));
    for (int i = 1; i < 4; i++) begin
      step();
      chk("z_show", led0, sx(UP, i));
      chk("z_show_done", 128'(done0), 128'(0));
    end
    step();
    chk("z_blank", led0, BLANK);
    chk("z_done", 128'(done0), 128'(1));
    chk("z_ready", 128'(ready0), 128'(1));
    chk("z_busy", 128'(busy0), 128'(0));
    step();
    chk("z_done_pulse", 128'(done0), 128'(0));

`ifdef SIMON_FRAME_BLINK_EN
    // blink: check, check, blank, blank, gap, gap, done
    valid = 1'b1; sym = 3'd5;
    step();
    valid = 1'b0;
    chk("bl_0", led, CHK);
    step();
    chk("bl_1", led, CHK);
    step();
    chk("bl_2", led, BLANK);
    chk("bl_2_busy", 128'(busy), 128'(1));
    step();
    chk("bl_3", led, BLANK);
    step();
    chk("bl_gap0", led, BLANK);
    chk("bl_gap0_done", 128'(done), 128'(0));
    step();
    chk("bl_gap1_done", 128'(done), 128'(0));
    step();
    chk("bl_done", 128'(done), 128'(1));
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
